// File: rtl/axis_pkg.sv
// Shared types and helpers for the valid/ready skid pipeline.
// Slice state codes double as the slice occupancy count.
package axis_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } slice_state_t;

   function automatic int clog2_min1(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// One full-throughput skid slice: main register drives the output,
// skid register catches the beat that arrives while downstream stalls.
module axis_skid_slice
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            occ
);

   slice_state_t          state_reg, state_next;
   logic [DATA_WIDTH-1:0] main_reg, skid_reg;
   logic                  ready_reg, valid_reg;
   logic                  in_fire, load_in, load_skid, main_from_skid;

   // ready_reg is low for one cycle after reset even though the slice is EMPTY
   assign in_fire = in_valid & ready_reg;

   always_comb begin
      state_next     = state_reg;
      load_in        = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state_reg)
         EMPTY: begin
            if (in_fire) begin
               load_in    = 1'b1;
               state_next = HALF;
            end
         end
         HALF: begin
            if (in_fire && out_ready) begin
               load_in = 1'b1;
            end else if (in_fire) begin
               load_skid  = 1'b1;
               state_next = FULL;
            end else if (out_ready) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (out_ready) begin
               main_from_skid = 1'b1;
               state_next     = HALF;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg <= EMPTY;
         ready_reg <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         ready_reg <= (state_next != FULL);
         valid_reg <= (state_next != EMPTY);
      end
   end

   // Payload registers carry no reset; out_data is only meaningful with out_valid
   always_ff @(posedge aclk) begin
      if (load_in) begin
         main_reg <= in_data;
      end else if (main_from_skid) begin
         main_reg <= skid_reg;
      end
      if (load_skid) begin
         skid_reg <= in_data;
      end
   end

   assign in_ready  = ready_reg;
   assign out_valid = valid_reg;
   assign out_data  = main_reg;
   assign occ       = state_reg;

endmodule

// File: rtl/axis_skid_pipe.sv
// Cascade of STAGES skid slices on a valid/ready stream; STAGES=0 is a wire.
// level reports the total number of beats held across all slices.
module axis_skid_pipe
   import axis_pkg::*;
#(
   parameter  int DATA_WIDTH  = 32,
   parameter  int STAGES      = 1,
   localparam int LEVEL_WIDTH = clog2_min1(2 * STAGES + 1)
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LEVEL_WIDTH-1:0] level
);

   generate
      if (STAGES == 0) begin : g_wire
         assign in_ready  = out_ready;
         assign out_data  = in_data;
         assign out_valid = in_valid;
         assign level     = '0;
      end else begin : g_pipe
         logic [DATA_WIDTH-1:0]  data_c  [STAGES+1];
         logic                   valid_c [STAGES+1];
         logic                   ready_c [STAGES+1];
         logic [1:0]             occ_c   [STAGES];
         logic [LEVEL_WIDTH-1:0] level_sum;

         assign data_c[0]       = in_data;
         assign valid_c[0]      = in_valid;
         assign in_ready        = ready_c[0];
         assign out_data        = data_c[STAGES];
         assign out_valid       = valid_c[STAGES];
         assign ready_c[STAGES] = out_ready;

         for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
            axis_skid_slice #(
               .DATA_WIDTH(DATA_WIDTH)
            ) u_slice (
               .aclk      (aclk),
               .areset    (areset),
               .in_data   (data_c[gi]),
               .in_valid  (valid_c[gi]),
               .in_ready  (ready_c[gi]),
               .out_data  (data_c[gi+1]),
               .out_valid (valid_c[gi+1]),
               .out_ready (ready_c[gi+1]),
               .occ       (occ_c[gi])
            );
         end

         // Sum of the slice state flops, so it moves on the same edge as the states
         always_comb begin
            level_sum = '0;
            for (int i = 0; i < STAGES; i++) begin
               level_sum = level_sum + LEVEL_WIDTH'(occ_c[i]);
            end
         end

         assign level = level_sum;
      end
   endgenerate

endmodule

// File: tb/tb_axis_skid_pipe.sv
// Bench for axis_skid_pipe at STAGES 0..3 against a queue-based stream model.
// The model holds accepted-but-not-emitted beats; level must equal its size.
module tb_axis_skid_pipe;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic        areset    [4];
   logic [31:0] in_data   [4];
   logic        in_valid  [4];
   logic        in_ready  [4];
   logic [31:0] out_data  [4];
   logic        out_valid [4];
   logic        out_ready [4];
   logic [3:0]  lvl       [4];

   logic [0:0] level0;
   logic [1:0] level1;
   logic [2:0] level2, level3;

   assign lvl[0] = {3'b000, level0};
   assign lvl[1] = {2'b00, level1};
   assign lvl[2] = {1'b0, level2};
   assign lvl[3] = {1'b0, level3};

   axis_skid_pipe #(.DATA_WIDTH(32), .STAGES(0)) u_s0 (
      .aclk(aclk), .areset(areset[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .level(level0));
   axis_skid_pipe #(.DATA_WIDTH(32), .STAGES(1)) u_s1 (
      .aclk(aclk), .areset(areset[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .level(level1));
   axis_skid_pipe #(.DATA_WIDTH(32), .STAGES(2)) u_s2 (
      .aclk(aclk), .areset(areset[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .level(level2));
   axis_skid_pipe #(.DATA_WIDTH(32), .STAGES(3)) u_s3 (
      .aclk(aclk), .areset(areset[3]), .in_data(in_data[3]), .in_valid(in_valid[3]),
      .in_ready(in_ready[3]), .out_data(out_data[3]), .out_valid(out_valid[3]),
      .out_ready(out_ready[3]), .level(level3));

   int          checks = 0;
   int          errors = 0;
   logic [31:0] q[$];
   int          n_in, n_out, cyc;
   logic        hold_prev;
   logic [31:0] hold_data;
   logic [31:0] last_out;
   logic        in_fire_l, out_fire_l;
   bit          verbose;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic reset_model();
      q.delete();
      hold_prev = 1'b0;
      n_in      = 0;
      n_out     = 0;
      cyc       = 0;
   endtask

   // Inputs are driven before the call; sample, update the model, advance one edge.
   task automatic do_cycle(input int idx);
      logic [31:0] exp_d;
      #1;
      check_val("level", 64'(lvl[idx]), 64'(q.size()));
      if (out_valid[idx]) check_val("valid_nonempty", 64'(q.size() != 0), 64'd1);
      if (hold_prev) begin
         check_val("hold_valid", 64'(out_valid[idx]), 64'd1);
         check_val("hold_data", 64'(out_data[idx]), 64'(hold_data));
      end
      in_fire_l  = in_valid[idx] & in_ready[idx];
      out_fire_l = out_valid[idx] & out_ready[idx];
      if (out_fire_l && q.size() != 0) begin
         exp_d = q.pop_front();
         check_val("out_data", 64'(out_data[idx]), 64'(exp_d));
         last_out = out_data[idx];
         n_out++;
         if (verbose) $display("S%0d beat out 0x%08h cycle %0d", idx, out_data[idx], cyc);
      end
      if (in_fire_l) begin
         q.push_back(in_data[idx]);
         n_in++;
      end
      hold_prev = out_valid[idx] & ~out_ready[idx];
      hold_data = out_data[idx];
      cyc++;
      @(posedge aclk);
      #1;
   endtask

   initial begin
      int          next, first_acc, first_out;
      bit          pend;

      verbose = 1'b1;
      for (int i = 0; i < 4; i++) begin
         areset[i]    = 1'b1;
         in_valid[i]  = 1'b0;
         in_data[i]   = '0;
         out_ready[i] = 1'b0;
      end
      reset_model();

      // Reset held for three edges, then released
      for (int k = 0; k < 3; k++) begin
         @(posedge aclk);
         #1;
         check_val("rst_in_ready", 64'(in_ready[2]), 64'd0);
         check_val("rst_out_valid", 64'(out_valid[2]), 64'd0);
         check_val("rst_level", 64'(lvl[2]), 64'd0);
      end
      for (int i = 0; i < 4; i++) areset[i] = 1'b0;
      @(posedge aclk);
      #1;
      check_val("post_rst_in_ready", 64'(in_ready[2]), 64'd1);
      check_val("post_rst_out_valid", 64'(out_valid[2]), 64'd0);
      check_val("post_rst_level", 64'(lvl[2]), 64'd0);
      check_val("post_rst_in_ready_s1", 64'(in_ready[1]), 64'd1);
      check_val("post_rst_in_ready_s3", 64'(in_ready[3]), 64'd1);

      // STAGES=0: combinational wire-through
      for (int i = 0; i < 20; i++) begin
         in_valid[0]  = 1'($urandom % 2);
         out_ready[0] = 1'($urandom % 2);
         in_data[0]   = (i == 0) ? 32'hA5A5_0001 : $urandom;
         #1;
         check_val("s0_data", 64'(out_data[0]), 64'(in_data[0]));
         check_val("s0_valid", 64'(out_valid[0]), 64'(in_valid[0]));
         check_val("s0_ready", 64'(in_ready[0]), 64'(out_ready[0]));
         check_val("s0_level", 64'(lvl[0]), 64'd0);
         if (in_valid[0] && out_ready[0])
            $display("S0 beat through 0x%08h", in_data[0]);
         @(posedge aclk);
         #1;
      end

      // STAGES=2: back-to-back stream, downstream always ready
      reset_model();
      out_ready[2] = 1'b1;
      next      = 1;
      first_acc = -1;
      first_out = -1;
      for (int b = 0; b < 200 && n_out < 16; b++) begin
         in_valid[2] = (next <= 16);
         in_data[2]  = 32'(next);
         if (out_valid[2] && first_out < 0) first_out = cyc;
         do_cycle(2);
         if (in_fire_l) begin
            if (first_acc < 0) first_acc = cyc - 1;
            next++;
         end
      end
      in_valid[2] = 1'b0;
      check_val("stream_count", 64'(n_out), 64'd16);
      check_val("stream_latency", 64'(first_out - first_acc), 64'd2);

      // STAGES=2: downstream stalled, capacity of four beats
      reset_model();
      out_ready[2] = 1'b0;
      next = 1;
      for (int b = 0; b < 10; b++) begin
         in_valid[2] = (next <= 5);
         in_data[2]  = 32'(next);
         do_cycle(2);
         if (in_fire_l) next++;
      end
      check_val("bp_accepted", 64'(n_in), 64'd4);
      check_val("bp_in_ready", 64'(in_ready[2]), 64'd0);
      check_val("bp_level", 64'(lvl[2]), 64'd4);
      out_ready[2] = 1'b1;
      for (int b = 0; b < 50 && n_out < 5; b++) begin
         in_valid[2] = (next <= 5);
         in_data[2]  = 32'(next);
         do_cycle(2);
         if (in_fire_l) next++;
      end
      in_valid[2] = 1'b0;
      check_val("bp_emitted", 64'(n_out), 64'd5);
      check_val("bp_last", 64'(last_out), 64'h5);

      // STAGES=1: reset while full discards held beats
      reset_model();
      out_ready[1] = 1'b0;
      next = 32'h11;
      for (int b = 0; b < 4; b++) begin
         in_valid[1] = 1'b1;
         in_data[1]  = 32'(next);
         do_cycle(1);
         if (in_fire_l) next++;
      end
      check_val("s1_full_level", 64'(lvl[1]), 64'd2);
      areset[1]   = 1'b1;
      in_data[1]  = 32'hDEAD_0000;
      @(posedge aclk);
      #1;
      reset_model();
      check_val("s1_rst_valid", 64'(out_valid[1]), 64'd0);
      check_val("s1_rst_level", 64'(lvl[1]), 64'd0);
      check_val("s1_rst_in_ready", 64'(in_ready[1]), 64'd0);
      areset[1]    = 1'b0;
      in_data[1]   = 32'h77;
      out_ready[1] = 1'b1;
      pend = 1'b1;
      for (int b = 0; b < 20 && n_out == 0; b++) begin
         in_valid[1] = pend;
         do_cycle(1);
         if (in_fire_l) pend = 1'b0;
      end
      in_valid[1] = 1'b0;
      check_val("s1_first_after_rst", 64'(last_out), 64'h77);
      check_val("s1_emitted", 64'(n_out), 64'd1);

      // STAGES=3: randomized traffic against the scoreboard
      verbose = 1'b0;
      reset_model();
      pend = 1'b0;
      for (int b = 0; b < 60000 && n_out < 10000; b++) begin
         if (!pend) begin
            pend       = 1'($urandom % 2);
            in_data[3] = $urandom;
         end
         in_valid[3]  = pend;
         out_ready[3] = 1'($urandom % 2);
         do_cycle(3);
         if (in_fire_l) pend = 1'b0;
      end
      in_valid[3] = 1'b0;
      $display("S3 random traffic: %0d beats in, %0d beats out", n_in, n_out);
      check_val("rand_done", 64'(n_out >= 10000), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_skid_pipe.md
Name: axis_skid_pipe

Overview:
- Parametrised successor to the combinational stream pass-through.
- Inserts STAGES cascaded full-throughput skid slices between an upstream and a downstream valid/ready stream.
- Breaks the timing paths on data, valid and ready.
- STAGES=0 gives a pure wire-through, so one block covers every pipelining need on stream links.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- STAGES, 1, number of cascaded skid slices; 0 = combinational pass-through; legal range 0..8.
- LEVEL_WIDTH, derived (localparam), $clog2(2*STAGES+1), minimum 1.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  upstream payload.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- out_data  out  DATA_WIDTH  downstream payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts a beat.
- level  out  LEVEL_WIDTH  beats currently held, 0..2*STAGES.

Behaviour:
- Handshake: a beat transfers on a port when valid and ready are both high at the rising edge.
- Once out_valid rises, out_valid and out_data hold until accepted; in_valid may be ignored until accepted.
- Order is preserved; no beat is dropped or duplicated.
- STAGES=0:
  - in_ready = out_ready, out_data = in_data, out_valid = in_valid, all combinational.
  - level tied to 0.
  - areset unused.
- STAGES>=1:
  - All of in_ready, out_valid, out_data and level are driven from flops; no combinational in-to-out path.
  - Slice k output feeds slice k+1 input.
- Per slice: main register (drives outputs), skid register, state in {EMPTY, HALF, FULL}.
- EMPTY: in_ready=1, out_valid=0. in_valid -> load main, go HALF.
- HALF: in_ready=1, out_valid=1.
  - in_valid & out_ready -> main<=in, stay HALF.
  - in_valid & !out_ready -> skid<=in, go FULL.
  - !in_valid & out_ready -> go EMPTY.
  - else hold.
- FULL: in_ready=0, out_valid=1. out_ready -> main<=skid, go HALF; else hold.
- in_ready is a registered decode: a flop set to (next_state != FULL).
- Throughput: 1 beat/cycle sustained when out_ready stays high.
- Latency: STAGES cycles from input handshake to out_valid through empty slices.
- Reset (areset high at an edge):
  - All slices go EMPTY; out_valid=0; level=0.
  - in_ready=0 while areset is high; in_ready=1 from the first edge after release.
  - Data registers are not reset; out_data is don't-care while out_valid=0.
- Reset mid-stream: all held beats are discarded. Upstream beats presented during reset are not accepted, since in_ready=0.
- Simultaneous accept and emit:
  - In HALF, the occupancy count is unchanged.
  - In FULL, in_ready=0, so only the emit occurs.
- level:
  - Registered sum of per-slice occupancy (EMPTY=0, HALF=1, FULL=2).
  - Updates on the same edge as the state change.
  - Never exceeds 2*STAGES.

Decomposition:
- Shared package axis_pkg holds:
  - slice state enum (EMPTY=2'd0, HALF=2'd1, FULL=2'd2);
  - function clog2_min1 for LEVEL_WIDTH.
- One sub-module, axis_skid_slice:
  - ports aclk, areset, in/out stream, occ[1:0];
  - instantiated STAGES times via generate;
  - the top sums the occ outputs into level.

Test Plan:
- STAGES=0, DATA_WIDTH=32: random in_valid/out_ready, in_data=0xA5A5_0001 -> outputs equal inputs combinationally in the same cycle; level=0.
- STAGES=2: areset high 3 cycles, then released -> in_ready=0, out_valid=0, level=0 during reset; in_ready=1 on the first cycle after.
- STAGES=2: out_ready=1, feed 0x01..0x10 back-to-back -> first out_valid 2 cycles after the first accept; then 1 beat/cycle in order 0x01..0x10; level steady at 2.
- STAGES=2: out_ready=0, feed 0x01..0x05 -> accepts exactly 4 beats; in_ready=0 after the 4th; level=4. Then out_ready=1 -> out sequence 0x01,0x02,0x03,0x04,0x05 with none lost.
- STAGES=1: areset asserted while level=2 -> next cycle out_valid=0, level=0; the next beat out after release is the first beat accepted after release.
- STAGES=3: randomized in_valid/out_ready (50%), 10k beats against a scoreboard:
  - order and data match;
  - out_data is stable while out_valid & !out_ready;
  - level equals accepted minus emitted.
